// File: rtl/ram_pkg.sv
// ram_pkg: shared address-width helper and request record for the RAM front end
package ram_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  localparam int ADDR_W_DEF = addr_w(DEPTH_DEF);
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;
endpackage

// File: rtl/ram_rsp_fifo.sv
// ram_rsp_fifo: small synchronous FIFO buffering read responses
module ram_rsp_fifo #(
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 2,
  localparam int CNT_W    = $clog2(RSP_DEPTH + 1),
  localparam int PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [CNT_W-1:0]  o_count,
  output logic [DATA_W-1:0] o_head
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(RSP_DEPTH - 1);
  logic [DATA_W-1:0] r_mem [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      if (i_pop) r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/ram_sp_req_port.sv
// ram_sp_req_port: valid/ready request front end for ram_sp_sync with credit-gated,
// in-order buffered read responses
module ram_sp_req_port
  import ram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int RSP_DEPTH = 2,
  localparam int ADDR_W   = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  logic             r_inflight;
  logic [CNT_W-1:0] w_count;
  logic             w_acc, w_pop, w_credit;
  // a slot is reserved for every read in flight, so the FIFO can never overflow
  assign w_pop       = rsp_valid_o & rsp_ready_i;
  assign w_credit    = (int'(w_count) + int'(r_inflight)) < RSP_DEPTH;
  assign req_ready_o = !rst & (w_credit | w_pop);
  assign w_acc       = req_valid_i & req_ready_o;
  assign mem_addr_o  = req_addr_i;
  assign mem_wdata_o = req_wdata_i;
  assign mem_wen_o   = w_acc & req_we_i;
  assign rsp_valid_o = w_count != '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_inflight <= 1'b0;
    else     r_inflight <= w_acc & !req_we_i;
  end
  ram_rsp_fifo #(.DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_wdata (mem_rdata_i),
    .o_count (w_count),
    .o_head  (rsp_rdata_o)
  );
endmodule
